regi_fifo: RTL and testbench
============================

# regi_fifo

Word-buffering stage directly upstream of the 32-bit register `regi`. Accepts 32-bit words from a producer, stores up to DEPTH of them in arrival order, and presents one word per accepted read on a registered output that drives `regi`'s D input. Decouples producer burst rate from the register's load rate and flags sticky overflow/underflow errors.

## Interface
- WIDTH, 32, data word width
- DEPTH, 4, number of storage entries; power of two, ≥ 2
- AW, log2(DEPTH), derived localparam, not overridable
- En  input  1  clock; all state updates on the rising edge
- r  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low
- wr_en  input  1  write request
- din  input  WIDTH  write data
- rd_en  input  1  read request
- dout  output  WIDTH  registered read data, to `regi` D
- dout_vld  output  1  high for exactly the cycle after an accepted read
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  AW+1  current occupancy, 0..DEPTH
- ovf  output  1  sticky overflow: write rejected
- unf  output  1  sticky underflow: read rejected

## Operation
- Storage: DEPTH × WIDTH array, write pointer `wp` and read pointer `rp`, each AW bits, wrap modulo DEPTH (DEPTH−1 → 0).
- Write accept: `wr_acc = wr_en & (~full | rd_acc)`; mem[wp] ← din, wp ← wp+1.
- Read accept: `rd_acc = rd_en & ~empty`; dout ← mem[rp], rp ← rp+1, dout_vld ← 1. Otherwise dout holds its value, dout_vld ← 0.
- count: +1 on write only, −1 on read only, unchanged on both or neither. full/empty are decoded from count (combinational, glitch-free from registered count).
- Simultaneous, full: both accepted; read returns the oldest word, new word takes the freed slot; count stays DEPTH.
- Simultaneous, empty: write accepted, read rejected (no pass-through); unf set; count → 1.
- ovf ← 1 when wr_en & full & ~rd_acc. unf ← 1 when rd_en & empty. Both cleared only by reset.
- Rejected operations change no pointer, count, mem entry, or dout.
- Reset (r = 0, any time, including mid-burst): wp, rp, count, dout, dout_vld, ovf, unf → 0; empty → 1, full → 0. mem contents need not be cleared. Takes effect immediately, no clock required. First edge after release of r behaves as normal operation.

## Timing
- Write-to-readable latency: word written on edge N is readable (empty deasserted) after edge N; an rd_en sampled at edge N+1 loads it into dout.
- Read latency: 1 cycle; dout/dout_vld valid after the edge that sampled rd_en.
- Throughput: one write and one read per cycle, sustained.
- full, empty, count, ovf, unf change only on clock edges or asynchronously on reset.
- Inputs sampled on the rising edge only; no combinational path from wr_en/rd_en/din to any output.

## Structure
- Shared include/package `regi_pkg`: default WIDTH (32), default DEPTH (4), clog2 helper function.
- One sub-module: `fifo_ptr` — AW-bit wrapping pointer with increment enable and async active-low clear; instantiated twice (wp, rp).
- Array, count, flags, and dout register live in `regi_fifo` top.

## Test plan
- Reset: drive r=0 mid-stream with count=3 -> count=0, empty=1, full=0, dout=0, ovf=unf=0 immediately, before next edge.
- Fill/drain order: write 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> full=1, count=4; four reads -> dout sequence 0x11111111…0x44444444, each with dout_vld one cycle, then empty=1.
- Overflow: full, wr_en=1 with din=0xDEADBEEF, rd_en=0 -> ovf=1, count stays 4, subsequent reads never return 0xDEADBEEF.
- Underflow: empty, rd_en=1 -> unf=1, dout unchanged, dout_vld=0, count 0.
- Simultaneous at full and at empty: full + both -> count 4, oldest word on dout, new word read out last; empty + wr/rd of 0xA5A5A5A5 -> count=1, unf=1, next read returns 0xA5A5A5A5.
- Wrap-around: 10 cycles of continuous write+read after 2 pre-loads (random data via $random) -> count held at 2, output order equals input order across pointer wrap, ovf=unf=0; dout feeding `regi` shows Q matching each word one cycle later.

Source files
------------

// File: rtl/regi_pkg.sv
// regi_pkg: shared defaults and a sizing helper for the regi datapath.
package regi_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;

    function automatic int clog2(input int v);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) n = i + 1;
        return n;
    endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: AW-bit wrapping pointer with increment enable and async active-low clear.
module fifo_ptr #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);
    logic [AW-1:0] ptr_d, ptr_q;

    always_comb ptr_d = inc ? ptr_q + AW'(1) : ptr_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;

    assign ptr = ptr_q;
endmodule

// File: rtl/regi_fifo.sv
// regi_fifo: DEPTH-entry word buffer feeding the regi register, with a registered
// read port and sticky overflow/underflow flags.
module regi_fifo
    import regi_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             En,
    input  logic             r,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             unf
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             wr_acc, rd_acc;
    logic [AW:0]      count_d, count_q;
    logic [WIDTH-1:0] dout_d, dout_q;
    logic             vld_d, vld_q, ovf_d, ovf_q, unf_d, unf_q;

    fifo_ptr #(.AW(AW)) u_wp (.clk(En), .rst_n(r), .inc(wr_acc), .ptr(wp));
    fifo_ptr #(.AW(AW)) u_rp (.clk(En), .rst_n(r), .inc(rd_acc), .ptr(rp));

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;

    // A full FIFO still takes a write when the same edge frees a slot; an empty one never passes through.
    always_comb begin
        rd_acc  = rd_en & ~empty;
        wr_acc  = wr_en & (~full | rd_acc);
        count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        dout_d  = rd_acc ? mem_q[rp] : dout_q;
        vld_d   = rd_acc;
        ovf_d   = ovf_q | (wr_en & full & ~rd_acc);
        unf_d   = unf_q | (rd_en & empty);
    end

    always_ff @(posedge En)
        if (wr_acc) mem_q[wp] <= din;

    always_ff @(posedge En or negedge r)
        if (!r) begin
            count_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
endmodule

// File: tb/tb_regi_fifo.sv
// tb_regi_fifo: scoreboard bench for regi_fifo with a behavioural regi register on dout.
module tb_regi_fifo;
    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0, r = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout, regi_q, m_dout, prev_dout, exp_w;
    logic         dout_vld, full, empty, ovf, unf;
    logic [2:0]   count;
    logic [W-1:0] mdl[$];
    logic [W-1:0] sb[$];
    bit           m_vld, m_ovf, m_unf;
    int           n_cmp = 0, n_bad = 0;

    regi_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .En(clk), .r(r), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_vld(dout_vld), .full(full), .empty(empty),
        .count(count), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge r)
        if (!r) regi_q <= '0;
        else    regi_q <= dout;

    task automatic reset_model();
        mdl.delete(); sb.delete();
        m_ovf = 0; m_unf = 0; m_vld = 0; m_dout = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk); r = 1'b0; #1; reset_model();
        @(negedge clk); r = 1'b1;
    endtask

    // Drives one cycle of stimulus and advances the reference model; expected reads go to sb.
    task automatic drive(input bit w, input bit rd, input logic [W-1:0] d);
        bit ra, wa;
        ra = rd && mdl.size() != 0;
        wa = w && (mdl.size() != D || ra);
        if (w && mdl.size() == D && !ra) m_ovf = 1;
        if (rd && mdl.size() == 0) m_unf = 1;
        if (ra) begin m_dout = mdl.pop_front(); sb.push_back(m_dout); end
        if (wa) mdl.push_back(d);
        m_vld = ra;
        prev_dout = dout;
        wr_en = w; rd_en = rd; din = d;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, W'(i + 1));
        drive(1, 0, 32'h5);
        drive(0, 1, '0);
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL pre_reset_count got %0d want 3", count); end
        #2; r = 1'b0; #1;
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if ({empty, full} !== 2'b10) begin n_bad++; $display("FAIL rst_empty_full got %b want 10", {empty, full}); end
        n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL rst_dout got %h want 0", dout); end
        n_cmp++; if ({dout_vld, ovf, unf} !== 3'b000) begin n_bad++; $display("FAIL rst_vld_ovf_unf got %b want 000", {dout_vld, ovf, unf}); end
        reset_model();
        @(negedge clk); r = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] v [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 0; i < 4; i++) drive(1, 0, v[i]);
        n_cmp++; if ({full, count} !== {1'b1, 3'd4}) begin n_bad++; $display("FAIL fill_full_count got %b/%0d want 1/4", full, count); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, '0);
            n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL drain_vld[%0d] got %b want 1", i, dout_vld); end
            if (dout_vld && sb.size() != 0) begin
                exp_w = sb.pop_front();
                n_cmp++; if (dout !== exp_w || dout !== v[i]) begin n_bad++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout, v[i]); end
            end
        end
        drive(0, 0, '0);
        n_cmp++; if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL vld_one_cycle got %b want 0", dout_vld); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drained_empty got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) drive(1, 0, 32'h100 + W'(i));
        drive(1, 0, 32'hDEADBEEF);
        n_cmp++; if ({ovf, count} !== {m_ovf, 3'd4}) begin n_bad++; $display("FAIL ovf_flag_count got %b/%0d want 1/4", ovf, count); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, '0);
            exp_w = sb.size() != 0 ? sb.pop_front() : 'x;
            n_cmp++; if (dout !== exp_w || dout === 32'hDEADBEEF) begin n_bad++; $display("FAIL ovf_drain[%0d] got %h want %h", i, dout, exp_w); end
        end
    endtask

    task automatic test_underflow();
        drive(0, 1, '0);
        n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL unf_flag got %b want 1", unf); end
        n_cmp++; if ({dout_vld, count} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL unf_vld_count got %b/%0d want 0/0", dout_vld, count); end
        n_cmp++; if (dout !== m_dout) begin n_bad++; $display("FAIL unf_dout_hold got %h want %h", dout, m_dout); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) drive(1, 0, 32'h200 + W'(i));
        drive(1, 1, 32'hCAFE0000);
        exp_w = sb.size() != 0 ? sb.pop_front() : 'x;
        n_cmp++; if ({dout_vld, count, dout} !== {1'b1, 3'd4, exp_w}) begin n_bad++; $display("FAIL full_both got vld=%b cnt=%0d dout=%h want 1/4/%h", dout_vld, count, dout, exp_w); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, '0);
            exp_w = sb.size() != 0 ? sb.pop_front() : 'x;
            n_cmp++; if (dout !== exp_w) begin n_bad++; $display("FAIL full_both_drain[%0d] got %h want %h", i, dout, exp_w); end
        end
        n_cmp++; if (dout !== 32'hCAFE0000) begin n_bad++; $display("FAIL new_word_last got %h want cafe0000", dout); end
        apply_reset();
        drive(1, 1, 32'hA5A5A5A5);
        n_cmp++; if ({count, unf, dout_vld} !== {3'd1, m_unf, 1'b0}) begin n_bad++; $display("FAIL empty_both got cnt=%0d unf=%b vld=%b want 1/1/0", count, unf, dout_vld); end
        drive(0, 1, '0);
        exp_w = sb.size() != 0 ? sb.pop_front() : 'x;
        n_cmp++; if (dout !== exp_w || dout !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL empty_both_read got %h want a5a5a5a5", dout); end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(1, 0, $urandom);
        drive(1, 0, $urandom);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, $urandom);
            exp_w = sb.size() != 0 ? sb.pop_front() : 'x;
            n_cmp++; if ({dout_vld, count} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL wrap_vld_count[%0d] got %b/%0d want 1/2", i, dout_vld, count); end
            n_cmp++; if (dout !== exp_w) begin n_bad++; $display("FAIL wrap_dout[%0d] got %h want %h", i, dout, exp_w); end
            n_cmp++; if (regi_q !== prev_dout) begin n_bad++; $display("FAIL regi_q[%0d] got %h want %h", i, regi_q, prev_dout); end
        end
        n_cmp++; if ({ovf, unf} !== {m_ovf, m_unf} || {ovf, unf} !== 2'b00) begin n_bad++; $display("FAIL wrap_flags got %b want 00", {ovf, unf}); end
    endtask

    initial begin
        reset_model();
        repeat (2) @(negedge clk);
        r = 1'b1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
